// File: rtl/qnsc3nreg_seq.sv
// ---------------------------------------------------------------------------
// qnsc3nreg_seq
//
// Multi-channel flash-regulator write-enable sequencer. It sits between the
// POC / regulator macros and the flash sequencer.
//
// A single debounced power-good qualifier (POCOK) is derived from the raw 5 V
// POC release. Every regulator channel then runs its own
// OFF -> RAMP -> ON -> DISCH -> OFF sequence. VCPRGWE is raised only after
// the regulator has had a programmable settling time. Each channel is
// independent of the others.
//
// Parameters
//   NCH       number of regulator channels (1..8)
//   SETTLE_W  width of the settle-count input and of the per-channel counters
//   FILT_LEN  consecutive synchronised-high POC samples needed for power-good
//             (1..15)
//
// Ports
//   CLK        in   1         system clock, rising edge
//   RESB       in   1         synchronous active-low reset
//   POCREL5V   in   1         raw POC release (asynchronous, 2-flop synced)
//   FLREGENB   in   NCH       per-channel regulator enable, active-low
//   SETTLE     in   SETTLE_W  ramp/discharge length in cycles (0 acts as 1)
//   ERRCLR     in   1         pulse that clears all ERRPOC bits
//   REGON      out  NCH       regulator power-on request (RAMP or ON)
//   VCPRGWE    out  NCH       program write enable (ON only)
//   ERRPOC     out  NCH       sticky: power-good lost while channel was ON
//   POCOK      out  1         debounced power-good
//   dbg_state  out  2*NCH     per-channel FSM state, channel i at [2i+1:2i]
//                             (0=OFF 1=RAMP 2=ON 3=DISCH)
//
// Handshake: there is no valid/ready pairing on this block. All inputs are
// level-sampled on every rising CLK edge. Every output is a registered level
// that can be read at any time after the edge that produced it.
// ---------------------------------------------------------------------------
module qnsc3nreg_seq #(
  parameter int NCH      = 2,
  parameter int SETTLE_W = 8,
  parameter int FILT_LEN = 4
) (
  input  logic                CLK,
  input  logic                RESB,
  input  logic                POCREL5V,
  input  logic [NCH-1:0]      FLREGENB,
  input  logic [SETTLE_W-1:0] SETTLE,
  input  logic                ERRCLR,
  output logic [NCH-1:0]      REGON,
  output logic [NCH-1:0]      VCPRGWE,
  output logic [NCH-1:0]      ERRPOC,
  output logic                POCOK,
  output logic [2*NCH-1:0]    dbg_state
);

  // -------------------------------------------------------------------------
  // Power-good path: 2-flop synchroniser followed by a saturating debounce
  // counter. A single low sample resets the counter, so power-good drops
  // quickly. Re-qualification needs FILT_LEN clean high samples.
  // -------------------------------------------------------------------------
  localparam int            FW   = $clog2(FILT_LEN + 1);
  localparam logic [FW-1:0] FMAX = FW'(FILT_LEN);
  localparam logic [FW-1:0] FONE = FW'(1);

  logic          sync1;
  logic          poc_s;
  logic [FW-1:0] fcnt;

  always_ff @(posedge CLK) begin
    if (!RESB) begin
      sync1 <= 1'b0;
      poc_s <= 1'b0;
      fcnt  <= '0;
    end else begin
      sync1 <= POCREL5V;
      poc_s <= sync1;
      if (!poc_s) begin
        fcnt <= '0;
      end else if (fcnt != FMAX) begin
        fcnt <= fcnt + FONE;
      end
    end
  end

  assign POCOK = (fcnt == FMAX);

  // -------------------------------------------------------------------------
  // Per-channel sequencer.
  // cnt counts cycles spent in RAMP or DISCH. It starts at 1 on entry, and
  // the state is left on the edge where cnt == cnt_lim. A limit of L
  // therefore gives exactly L cycles in the state. cnt_lim is captured on
  // entry, so later SETTLE changes cannot stretch or cut a count in progress.
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_RAMP  = 2'd1,
    S_ON    = 2'd2,
    S_DISCH = 2'd3
  } state_t;

  localparam logic [SETTLE_W-1:0] CNT_ONE = SETTLE_W'(1);

  state_t              state_q [NCH];
  state_t              state_d [NCH];
  logic [SETTLE_W-1:0] cnt_q   [NCH];
  logic [SETTLE_W-1:0] cnt_d   [NCH];
  logic [SETTLE_W-1:0] lim_q   [NCH];
  logic [SETTLE_W-1:0] lim_d   [NCH];
  logic [NCH-1:0]      err_set;
  logic [NCH-1:0]      errpoc_q;
  logic [SETTLE_W-1:0] settle_eff;

  // A SETTLE of zero would never match a counter that starts at 1, so it is
  // promoted to the shortest legal length.
  assign settle_eff = (SETTLE == '0) ? CNT_ONE : SETTLE;

  always_comb begin
    err_set = '0;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      lim_d[i]   = lim_q[i];

      case (state_q[i])
        S_OFF: begin
          if (POCOK && !FLREGENB[i]) begin
            state_d[i] = S_RAMP;
            lim_d[i]   = settle_eff;
            cnt_d[i]   = CNT_ONE;
          end
        end

        S_RAMP: begin
          if (!POCOK) begin
            state_d[i] = S_OFF;
            cnt_d[i]   = '0;
          end else if (FLREGENB[i]) begin
            // An aborted ramp still gets a full discharge period.
            state_d[i] = S_DISCH;
            lim_d[i]   = settle_eff;
            cnt_d[i]   = CNT_ONE;
          end else if (cnt_q[i] == lim_q[i]) begin
            state_d[i] = S_ON;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end

        S_ON: begin
          if (!POCOK) begin
            state_d[i] = S_OFF;
            cnt_d[i]   = '0;
            err_set[i] = 1'b1;
          end else if (FLREGENB[i]) begin
            state_d[i] = S_DISCH;
            lim_d[i]   = settle_eff;
            cnt_d[i]   = CNT_ONE;
          end
        end

        S_DISCH: begin
          // The request is deliberately ignored here: a channel must reach
          // OFF before it can ramp again.
          if (!POCOK || (cnt_q[i] == lim_q[i])) begin
            state_d[i] = S_OFF;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end

        default: begin
          state_d[i] = S_OFF;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NCH; i++) begin
      if (!RESB) begin
        state_q[i] <= S_OFF;
        cnt_q[i]   <= '0;
        lim_q[i]   <= '0;
      end else begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        lim_q[i]   <= lim_d[i];
      end
    end
  end

  // A new error event beats a simultaneous clear, so the event is never lost.
  always_ff @(posedge CLK) begin
    if (!RESB) begin
      errpoc_q <= '0;
    end else begin
      errpoc_q <= (errpoc_q & ~{NCH{ERRCLR}}) | err_set;
    end
  end

  assign ERRPOC = errpoc_q;

  // -------------------------------------------------------------------------
  // Outputs are decoded purely from the state register. They therefore
  // change only at clock edges, and no input reaches them combinationally.
  // -------------------------------------------------------------------------
  always_comb begin
    REGON     = '0;
    VCPRGWE   = '0;
    dbg_state = '0;
    for (int i = 0; i < NCH; i++) begin
      REGON[i]         = (state_q[i] == S_RAMP) || (state_q[i] == S_ON);
      VCPRGWE[i]       = (state_q[i] == S_ON);
      dbg_state[2*i +: 2] = state_q[i];
    end
  end

endmodule

// File: doc/qnsc3nreg_seq.md
# qnsc3nreg_seq

Parametrised, clocked successor to the single-channel flash regulator write-enable gate. It drives NCH independent flash-regulator channels. The 5 V power-on-clear release (POCREL5V) is synchronised and debounced into one global power-good qualifier. Each channel runs a ramp/settle/discharge state machine, so VCPRGWE asserts only after its regulator has had a programmable settling time. It sits between the POC/regulator macros and the flash sequencer.

## Interface
- NCH, default 2: number of regulator channels (1..8).
- SETTLE_W, default 8: width of the settle-count input.
- FILT_LEN, default 4: consecutive synchronised-high samples of POCREL5V required before power-good (1..15).

- CLK  input  1  system clock; all state updates on rising edge.
- RESB  input  1  reset; synchronous, active-low.
- POCREL5V  input  1  raw POC release from the 5 V domain; asynchronous; 2-flop synchronised internally.
- FLREGENB  input  NCH  per-channel regulator enable, active-low; synchronous to CLK.
- SETTLE  input  SETTLE_W  ramp/discharge cycle count; latched on RAMP or DISCH entry.
- ERRCLR  input  1  one-cycle pulse; clears all ERRPOC bits.
- REGON  output  NCH  regulator power-on request per channel.
- VCPRGWE  output  NCH  program write enable per channel; high only in ON.
- ERRPOC  output  NCH  sticky flag: power-good was lost while the channel was in ON.
- POCOK  output  1  debounced power-good.

## Operation
- POC path:
  - Sync chain is sync1 then poc_s.
  - Counter fcnt, width ceil(log2(FILT_LEN+1)): increments while poc_s=1, saturates at FILT_LEN, clears to 0 on any poc_s=0.
  - POCOK = (fcnt==FILT_LEN).
  - Assertion needs FILT_LEN high samples. Deassertion happens on the first low sample.
- Per-channel FSM, 2-bit state, registered. Define req[i] = POCOK & ~FLREGENB[i].
  - OFF: when req[i]=1, go to RAMP, latch cnt_lim=max(SETTLE,1), cnt=1.
  - RAMP: REGON=1, VCPRGWE=0, cnt increments each cycle. Transitions, in priority order:
    - POCOK=0: go to OFF.
    - FLREGENB[i]=1: go to DISCH and reload the count.
    - cnt==cnt_lim: go to ON.
  - ON: REGON=1, VCPRGWE=1. Transitions, in priority order:
    - POCOK=0: go to OFF and set ERRPOC[i].
    - FLREGENB[i]=1: go to DISCH, latch cnt_lim=max(SETTLE,1), cnt=1.
  - DISCH: REGON=0, VCPRGWE=0, cnt increments.
    - POCOK=0: go to OFF.
    - cnt==cnt_lim: go to OFF.
    - req[i] is ignored until OFF is reached, so there is no re-ramp without discharge.
- REGON and VCPRGWE are decoded from the state register only, so they are glitch-free and have no combinational input-to-output path.
- ERRPOC[i]:
  - Set on the ON-to-OFF transition caused by POCOK=0.
  - Cleared by ERRCLR.
  - If set and ERRCLR fall on the same edge, set wins.
- Channels are fully independent. Simultaneous requests on several channels all ramp in parallel.
- Counter width is SETTLE_W. SETTLE=0 is treated as 1.
- SETTLE changes after entry do not affect a count already in progress.

## Timing
- Reset with RESB=0 at a rising edge gives: all FSMs OFF, sync1=poc_s=0, fcnt=0, cnt=0. Outputs then read REGON=0, VCPRGWE=0, ERRPOC=0, POCOK=0. Reset overrides ERRCLR and every transition; reset mid-RAMP or mid-ON drops outputs at the next edge.
- POCREL5V rise sampled at edge k: POCOK=1 after edge k+1+FILT_LEN. POCREL5V fall sampled at edge k: POCOK=0 after edge k+2.
- FLREGENB[i] falling with POCOK=1 at edge n:
  - REGON[i]=1 after edge n.
  - VCPRGWE[i]=1 after edge n+max(SETTLE,1).
- FLREGENB[i] rising in ON at edge m:
  - VCPRGWE[i]=0 and REGON[i]=0 after edge m.
  - OFF after edge m+max(SETTLE,1); a new RAMP is possible at edge m+max(SETTLE,1)+1 at the earliest.
- POCOK falling forces every non-OFF channel to OFF on the next edge, regardless of count.

## Test plan
- Reset/POC debounce: FILT_LEN=4, RESB low 3 cycles then high, POCREL5V high → POCOK rises exactly 5 edges after the first sampling edge; all outputs 0 throughout reset.
- Nominal ramp: SETTLE=10, FLREGENB[0] falls → REGON[0] next edge, VCPRGWE[0] exactly 10 edges after FLREGENB[0] falls; channel 1 (FLREGENB[1]=1) stays 0.
- Discharge/re-request: in ON, FLREGENB[0] high for 2 cycles, then low → REGON/VCPRGWE drop next edge; new RAMP starts only after 10-cycle DISCH completes.
- POC glitch: POCREL5V low for 1 sample while channel 0 in ON, channel 1 in RAMP → POCOK drops; both go OFF; only ERRPOC[0] sets. ERRCLR pulsed on the same edge as the set leaves ERRPOC[0]=1; a later ERRCLR clears it.
- Boundaries: SETTLE=0 gives ON one edge after RAMP entry. SETTLE changed mid-RAMP leaves timing unchanged. SETTLE=255 (max) with SETTLE_W=8 reaches ON without wrap. Glitch on POCREL5V shorter than FILT_LEN during power-up never asserts POCOK.
